// File: rtl/dif_tf_pkg.sv
// Shared defaults for the radix-16 DIF twiddle constant bank.
// Holds the row-0 reset constants (tf1/tf5/tf9/tf13) and the default table geometry.
package dif_tf_pkg;

  localparam int TF_P_WIDTH   = 64;
  localparam int TF_NUM_CH    = 4;
  localparam int TF_NUM_STAGE = 4;

  localparam logic [63:0] TF_ROW0_DEF [4] = '{
    64'h381d997f2d35d682,
    64'h252502e45f699196,
    64'h4a3f9ccc62d9a86a,
    64'h75c91fcd00f90ea6
  };

  // Channels beyond the four known constants reset to zero.
  function automatic logic [63:0] tf_default(input int ch);
    case (ch)
      0:       return TF_ROW0_DEF[0];
      1:       return TF_ROW0_DEF[1];
      2:       return TF_ROW0_DEF[2];
      3:       return TF_ROW0_DEF[3];
      default: return 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/dif_tf_const_bank.sv
// Per-stage twiddle constant table with run-time reload; registered row output, 1-cycle read latency.
// No backpressure: one read and one write accepted every cycle; out-of-range requests raise sticky Q_err.
module dif_tf_const_bank
  import dif_tf_pkg::*;
#(
  parameter int P_WIDTH   = TF_P_WIDTH,
  parameter int NUM_CH    = TF_NUM_CH,
  parameter int NUM_STAGE = TF_NUM_STAGE,
  parameter int SC_WIDTH  = 3,
  parameter int CH_WIDTH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SC_WIDTH-1:0]         stage_counter,
  input  logic                        CEN,
  input  logic                        cfg_we,
  input  logic [SC_WIDTH-1:0]         cfg_stage,
  input  logic [CH_WIDTH-1:0]         cfg_ch,
  input  logic [P_WIDTH-1:0]          cfg_data,
  output logic [NUM_CH*P_WIDTH-1:0]   Q_tf,
  output logic                        Q_valid,
  output logic                        Q_err
);

  logic [P_WIDTH-1:0]        tbl_q [NUM_STAGE][NUM_CH];
  logic [NUM_CH*P_WIDTH-1:0] tf_q, tf_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic                      rd_req, rd_ok, wr_ok;

  always_comb begin
    rd_req  = !CEN;
    rd_ok   = 32'(stage_counter) < 32'(NUM_STAGE);
    wr_ok   = (32'(cfg_stage) < 32'(NUM_STAGE)) && (32'(cfg_ch) < 32'(NUM_CH));
    tf_d    = tf_q;
    valid_d = 1'b0;
    err_d   = err_q;
    // The row mux reads the pre-edge table, giving read-before-write on a same-row collision.
    if (rd_req && rd_ok) begin
      valid_d = 1'b1;
      for (int s = 0; s < NUM_STAGE; s++) begin
        if (32'(stage_counter) == 32'(s)) begin
          for (int c = 0; c < NUM_CH; c++) begin
            tf_d[c*P_WIDTH +: P_WIDTH] = tbl_q[s][c];
          end
        end
      end
    end
    if ((rd_req && !rd_ok) || (cfg_we && !wr_ok)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < NUM_STAGE; s++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          tbl_q[s][c] <= (s == 0) ? P_WIDTH'(tf_default(c)) : '0;
        end
      end
    end else if (cfg_we && wr_ok) begin
      for (int s = 0; s < NUM_STAGE; s++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if ((32'(cfg_stage) == 32'(s)) && (32'(cfg_ch) == 32'(c))) begin
            tbl_q[s][c] <= cfg_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tf_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tf_q    <= tf_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign Q_tf    = tf_q;
  assign Q_valid = valid_q;
  assign Q_err   = err_q;

endmodule

// File: tb/tb_dif_tf_const_bank.sv
// Directed bench for dif_tf_const_bank: default row, reload, read-before-write, range errors, streaming and reset.
module tb_dif_tf_const_bank;

  localparam logic [63:0] D0 = 64'h381d997f2d35d682;
  localparam logic [63:0] D1 = 64'h252502e45f699196;
  localparam logic [63:0] D2 = 64'h4a3f9ccc62d9a86a;
  localparam logic [63:0] D3 = 64'h75c91fcd00f90ea6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   stage_counter;
  logic         CEN;
  logic         cfg_we;
  logic [2:0]   cfg_stage;
  logic [1:0]   cfg_ch;
  logic [63:0]  cfg_data;
  logic [255:0] Q_tf;
  logic         Q_valid;
  logic         Q_err;

  int n_checks = 0;
  int n_fail   = 0;

  dif_tf_const_bank dut (
    .clk(clk), .rst_n(rst_n), .stage_counter(stage_counter), .CEN(CEN),
    .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .Q_tf(Q_tf), .Q_valid(Q_valid), .Q_err(Q_err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] row(input logic [63:0] c0, input logic [63:0] c1,
                                       input logic [63:0] c2, input logic [63:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CEN = 1'b1; cfg_we = 1'b0; stage_counter = '0;
    cfg_stage = '0; cfg_ch = '0; cfg_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    CEN = 1'b0; cfg_we = 1'b1; stage_counter = '0;
    cfg_stage = 3'd1; cfg_ch = 2'd0; cfg_data = 64'hdead;
    tick();
    tick();
    rst_n = 1'b0;
    idle();
    n_checks++; if (Q_tf !== '0)     begin n_fail++; $display("FAIL reset_tf got %h want 0", Q_tf); end
    n_checks++; if (Q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", Q_valid); end
    n_checks++; if (Q_err !== 1'b0)   begin n_fail++; $display("FAIL reset_err got %b want 0", Q_err); end
    // Write presented during reset must be ignored: row 1 stays zero.
    CEN = 1'b0; stage_counter = 3'd1;
    tick();
    idle();
    n_checks++; if (Q_tf !== '0) begin n_fail++; $display("FAIL reset_ignores_write got %h want 0", Q_tf); end
  endtask

  task automatic test_default_read();
    CEN = 1'b0; stage_counter = 3'd0;
    tick();
    idle();
    n_checks++; if (Q_valid !== 1'b1) begin n_fail++; $display("FAIL default_valid got %b want 1", Q_valid); end
    n_checks++; if (Q_tf !== row(D0, D1, D2, D3)) begin n_fail++; $display("FAIL default_row got %h want %h", Q_tf, row(D0, D1, D2, D3)); end
    tick();
    n_checks++; if (Q_valid !== 1'b0) begin n_fail++; $display("FAIL cen_high_valid got %b want 0", Q_valid); end
    n_checks++; if (Q_tf !== row(D0, D1, D2, D3)) begin n_fail++; $display("FAIL cen_high_hold got %h want %h", Q_tf, row(D0, D1, D2, D3)); end
  endtask

  task automatic test_write_read();
    cfg_we = 1'b1; cfg_stage = 3'd2; cfg_ch = 2'd1; cfg_data = 64'h0123456789abcdef;
    tick();
    idle();
    CEN = 1'b0; stage_counter = 3'd2;
    tick();
    idle();
    n_checks++; if (Q_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid got %b want 1", Q_valid); end
    n_checks++; if (Q_tf !== row(64'h0, 64'h0123456789abcdef, 64'h0, 64'h0)) begin
      n_fail++; $display("FAIL wr_rd_row2 got %h want %h", Q_tf, row(64'h0, 64'h0123456789abcdef, 64'h0, 64'h0)); end
  endtask

  task automatic test_read_before_write();
    cfg_we = 1'b1; cfg_stage = 3'd0; cfg_ch = 2'd0; cfg_data = 64'h1;
    CEN = 1'b0; stage_counter = 3'd0;
    tick();
    cfg_we = 1'b0;
    n_checks++; if (Q_tf !== row(D0, D1, D2, D3)) begin n_fail++; $display("FAIL rbw_old got %h want %h", Q_tf, row(D0, D1, D2, D3)); end
    tick();
    idle();
    n_checks++; if (Q_tf !== row(64'h1, D1, D2, D3)) begin n_fail++; $display("FAIL rbw_new got %h want %h", Q_tf, row(64'h1, D1, D2, D3)); end
  endtask

  task automatic test_oob_read();
    CEN = 1'b0; stage_counter = 3'd5;
    tick();
    idle();
    n_checks++; if (Q_valid !== 1'b0) begin n_fail++; $display("FAIL oob_rd_valid got %b want 0", Q_valid); end
    n_checks++; if (Q_tf !== row(64'h1, D1, D2, D3)) begin n_fail++; $display("FAIL oob_rd_hold got %h want %h", Q_tf, row(64'h1, D1, D2, D3)); end
    n_checks++; if (Q_err !== 1'b1) begin n_fail++; $display("FAIL oob_rd_err got %b want 1", Q_err); end
    CEN = 1'b0; stage_counter = 3'd3;
    tick();
    idle();
    tick();
    tick();
    n_checks++; if (Q_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", Q_err); end
    do_reset();
    n_checks++; if (Q_err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_reset got %b want 0", Q_err); end
  endtask

  task automatic test_oob_write();
    logic [255:0] exp_rows [4];
    exp_rows[0] = row(D0, D1, D2, D3);
    exp_rows[1] = '0;
    exp_rows[2] = '0;
    exp_rows[3] = '0;
    cfg_we = 1'b1; cfg_stage = 3'd4; cfg_ch = 2'd0; cfg_data = 64'hffff_ffff_ffff_ffff;
    tick();
    idle();
    n_checks++; if (Q_err !== 1'b1) begin n_fail++; $display("FAIL oob_wr_err got %b want 1", Q_err); end
    for (int s = 0; s < 4; s++) begin
      CEN = 1'b0; stage_counter = 3'(s);
      tick();
      n_checks++; if (Q_tf !== exp_rows[s]) begin n_fail++; $display("FAIL oob_wr_row%0d got %h want %h", s, Q_tf, exp_rows[s]); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp_rows [4];
    exp_rows[0] = row(D0, D1, D2, D3);
    exp_rows[1] = row(64'h0, 64'h0, 64'haaaa_0000_1111_2222, 64'h0);
    exp_rows[2] = row(64'h0, 64'h0, 64'h0, 64'hbbbb_3333_4444_5555);
    exp_rows[3] = row(64'hcccc_6666_7777_8888, 64'h0, 64'h0, 64'h0);
    do_reset();
    cfg_we = 1'b1;
    cfg_stage = 3'd1; cfg_ch = 2'd2; cfg_data = 64'haaaa_0000_1111_2222; tick();
    cfg_stage = 3'd2; cfg_ch = 2'd3; cfg_data = 64'hbbbb_3333_4444_5555; tick();
    cfg_stage = 3'd3; cfg_ch = 2'd0; cfg_data = 64'hcccc_6666_7777_8888; tick();
    cfg_we = 1'b0;
    for (int s = 0; s < 4; s++) begin
      CEN = 1'b0; stage_counter = 3'(s);
      tick();
      n_checks++; if (Q_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d got %b want 1", s, Q_valid); end
      n_checks++; if (Q_tf !== exp_rows[s]) begin n_fail++; $display("FAIL stream_row%0d got %h want %h", s, Q_tf, exp_rows[s]); end
    end
    CEN = 1'b1;
    tick();
    n_checks++; if (Q_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid got %b want 0", Q_valid); end
    n_checks++; if (Q_tf !== exp_rows[3]) begin n_fail++; $display("FAIL gap_hold got %h want %h", Q_tf, exp_rows[3]); end
    n_checks++; if (Q_err !== 1'b0) begin n_fail++; $display("FAIL stream_err got %b want 0", Q_err); end
    rst_n = 1'b1; CEN = 1'b0; stage_counter = 3'd1;
    tick();
    rst_n = 1'b0;
    idle();
    n_checks++; if (Q_tf !== '0) begin n_fail++; $display("FAIL midreset_tf got %h want 0", Q_tf); end
    n_checks++; if (Q_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", Q_valid); end
    CEN = 1'b0; stage_counter = 3'd2;
    tick();
    idle();
    n_checks++; if (Q_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_rd_valid got %b want 1", Q_valid); end
    n_checks++; if (Q_tf !== '0) begin n_fail++; $display("FAIL midreset_row2 got %h want 0", Q_tf); end
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    test_reset();
    test_default_read();
    test_write_read();
    test_read_before_write();
    test_oob_read();
    test_oob_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
